pipe_stage_skid: RTL and testbench

- Parametrised successor to the fixed MEM/WB latch: a generic pipeline stage register with valid/ready handshake, a one-entry skid buffer, synchronous flush and bubble zeroing.
- Placed between any two CPU pipeline stages (IF/ID, ID/EX, EX/MEM, MEM/WB) so a downstream stall (e.g. data-cache miss) back-pressures upstream without combinational ready chains.
- Payload is an opaque bit vector. Each instantiating stage packs its own control and data fields into it.

---
 rtl/cpu_pipe_pkg.sv | 67 ++++++
 rtl/pipe_stage_skid_sat_counter.sv | 35 +++
 rtl/pipe_stage_skid.sv | 129 ++++++++++++
 tb/tb_pipe_stage_skid.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pipe_pkg.sv
// Shared definitions for the CPU pipeline stage registers: per-stage payload
// widths, field offsets used to pack/unpack stage payloads, and the state
// encoding of the skid-buffered stage register.
package cpu_pipe_pkg;

    // Per-stage payload widths
    // IF/ID : PC 32 + instruction 32
    localparam int IFID_W  = 64;
    // ID/EX : ctrl 7 (RegWrite, MemtoReg, MemRead, MemWrite, ALUSrc, ALUOp[1:0])
    //         + RD1 32 + RD2 32 + Imm 32 + rs 5 + rt 5 + rd 5
    localparam int IDEX_W  = 118;
    // EX/MEM: RegWrite, MemtoReg, MemRead, MemWrite + ALUdata 32 + WriteData 32 + RDaddr 5
    localparam int EXMEM_W = 73;
    // MEM/WB: RegWrite 1 + MemtoReg 1 + ReadData 32 + ALUdata 32 + RDaddr 5
    localparam int MEMWB_W = 71;

    // MEM/WB field offsets (LSB positions)
    localparam int MEMWB_RDADDR_LSB   = 0;
    localparam int MEMWB_ALUDATA_LSB  = 5;
    localparam int MEMWB_READDATA_LSB = 37;
    localparam int MEMWB_MEMTOREG_BIT = 69;
    localparam int MEMWB_REGWRITE_BIT = 70;

    // EX/MEM field offsets (LSB positions)
    localparam int EXMEM_RDADDR_LSB    = 0;
    localparam int EXMEM_WRDATA_LSB    = 5;
    localparam int EXMEM_ALUDATA_LSB   = 37;
    localparam int EXMEM_MEMWRITE_BIT  = 69;
    localparam int EXMEM_MEMREAD_BIT   = 70;
    localparam int EXMEM_MEMTOREG_BIT  = 71;
    localparam int EXMEM_REGWRITE_BIT  = 72;

    // IF/ID field offsets (LSB positions)
    localparam int IFID_INSTR_LSB = 0;
    localparam int IFID_PC_LSB    = 32;

    // Stage register state; the encoding doubles as the occupancy count
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    // Number of held entries for a given state
    function automatic logic [1:0] state_occupancy(input pipe_state_e s);
        logic [1:0] occ;
        case (s)
            EMPTY:   occ = 2'd0;
            ONE:     occ = 2'd1;
            FULL:    occ = 2'd2;
            default: occ = 2'd0;
        endcase
        return occ;
    endfunction

    // Pack the MEM/WB fields into one opaque payload word
    function automatic logic [MEMWB_W-1:0] memwb_pack(
        input logic        regwrite,
        input logic        memtoreg,
        input logic [31:0] readdata,
        input logic [31:0] aludata,
        input logic [4:0]  rdaddr
    );
        return {regwrite, memtoreg, readdata, aludata, rdaddr};
    endfunction

endpackage

// File: rtl/pipe_stage_skid_sat_counter.sv
// Saturating up-counter with a 0..3 increment per cycle and synchronous clear.
// Sticks at all-ones instead of wrapping; reusable for performance counters.
module pipe_stage_skid_sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             clr_i,
    input  logic [1:0]       inc_i,
    output logic [CNT_W-1:0] cnt_o
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W+1:0] w_sum;
    logic [CNT_W+1:0] w_max;
    logic [CNT_W-1:0] w_cnt_next;

    // Widen by two bits so the sum can never overflow before the clamp
    always_comb begin
        w_sum      = {2'b00, r_cnt} + {{CNT_W{1'b0}}, inc_i};
        w_max      = {2'b00, {CNT_W{1'b1}}};
        w_cnt_next = (w_sum > w_max) ? {CNT_W{1'b1}} : w_sum[CNT_W-1:0];
    end

    // Counter register; clear has priority over any increment
    always_ff @(posedge clk_i) begin
        if (clr_i) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= w_cnt_next;
        end
    end

    assign cnt_o = r_cnt;

endmodule

// File: rtl/pipe_stage_skid.sv
// Generic pipeline stage register with valid/ready handshake and a one-entry
// skid buffer. up_ready_o is a flop, so a downstream stall never forms a
// combinational ready chain through the pipeline. Supports synchronous flush
// (with a count of discarded entries) and optional bubble zeroing.
module pipe_stage_skid
    import cpu_pipe_pkg::*;
#(
    parameter int PAYLOAD_W   = MEMWB_W,
    parameter bit ZERO_BUBBLE = 1'b1,
    parameter int CNT_W       = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 up_valid_i,
    output logic                 up_ready_o,
    input  logic [PAYLOAD_W-1:0] up_data_i,
    output logic                 down_valid_o,
    input  logic                 down_ready_i,
    output logic [PAYLOAD_W-1:0] down_data_o,
    output logic [1:0]           occupancy_o,
    output logic [CNT_W-1:0]     flush_drop_cnt_o
);

    pipe_state_e          r_state;
    pipe_state_e          w_state_next;
    logic [PAYLOAD_W-1:0] r_main;       // older entry, drives down_data_o
    logic [PAYLOAD_W-1:0] r_skid;       // younger entry, only valid in FULL
    logic [PAYLOAD_W-1:0] w_main_next;
    logic [PAYLOAD_W-1:0] w_skid_next;
    logic                 r_up_ready;
    logic                 r_down_valid;
    logic [1:0]           r_occupancy;
    logic                 w_in_fire;
    logic                 w_out_fire;
    logic [1:0]           w_drop_inc;

    assign w_in_fire  = up_valid_i & r_up_ready;
    assign w_out_fire = r_down_valid & down_ready_i;

    // Next-state and datapath selection; flush overrides every handshake
    always_comb begin
        w_state_next = r_state;
        w_main_next  = r_main;
        w_skid_next  = r_skid;
        if (flush_i) begin
            w_state_next = EMPTY;
            if (ZERO_BUBBLE) begin
                w_main_next = '0;
                w_skid_next = '0;
            end
        end else begin
            case (r_state)
                EMPTY: begin
                    if (w_in_fire) begin
                        w_main_next  = up_data_i;
                        w_state_next = ONE;
                    end
                end
                ONE: begin
                    if (w_in_fire && w_out_fire) begin
                        // Pass-through at full throughput
                        w_main_next = up_data_i;
                    end else if (w_in_fire) begin
                        // Downstream stalled: park the new entry behind main
                        w_skid_next  = up_data_i;
                        w_state_next = FULL;
                    end else if (w_out_fire) begin
                        w_state_next = EMPTY;
                        if (ZERO_BUBBLE) begin
                            w_main_next = '0;
                        end
                    end
                end
                FULL: begin
                    if (w_out_fire) begin
                        w_main_next  = r_skid;
                        w_state_next = ONE;
                        if (ZERO_BUBBLE) begin
                            w_skid_next = '0;
                        end
                    end
                end
                default: begin
                    w_state_next = EMPTY;
                    w_main_next  = '0;
                    w_skid_next  = '0;
                end
            endcase
        end
    end

    // State, payload and decoded status flops; reset beats flush and handshakes
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state      <= EMPTY;
            r_main       <= '0;
            r_skid       <= '0;
            r_up_ready   <= 1'b1;
            r_down_valid <= 1'b0;
            r_occupancy  <= 2'd0;
        end else begin
            r_state      <= w_state_next;
            r_main       <= w_main_next;
            r_skid       <= w_skid_next;
            r_up_ready   <= (w_state_next != FULL);
            r_down_valid <= (w_state_next != EMPTY);
            r_occupancy  <= state_occupancy(w_state_next);
        end
    end

    // Entries held at the moment of a flush are the ones being discarded
    assign w_drop_inc = flush_i ? r_occupancy : 2'd0;

    pipe_stage_skid_sat_counter #(
        .CNT_W (CNT_W)
    ) u_drop_cnt (
        .clk_i (clk_i),
        .clr_i (rst_i),
        .inc_i (w_drop_inc),
        .cnt_o (flush_drop_cnt_o)
    );

    assign up_ready_o   = r_up_ready;
    assign down_valid_o = r_down_valid;
    assign down_data_o  = r_main;
    assign occupancy_o  = r_occupancy;

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Bench for pipe_stage_skid: two instances share all inputs, one with bubble
// zeroing and a 16-bit drop counter, one holding stale data with a 2-bit
// counter. A queue scoreboard tracks accepted payloads; a vector table holds
// hand-derived expected outputs for the stream, stall, flush and reset cases.
module tb_pipe_stage_skid;

    localparam int W = 71;

    logic         clk;
    logic         rst_i;
    logic         flush_i;
    logic         up_valid_i;
    logic [W-1:0] up_data_i;
    logic         down_ready_i;

    logic         a_up_ready, a_down_valid;
    logic [W-1:0] a_down_data;
    logic [1:0]   a_occ;
    logic [15:0]  a_cnt;

    logic         b_up_ready, b_down_valid;
    logic [W-1:0] b_down_data;
    logic [1:0]   b_occ;
    logic [1:0]   b_cnt;

    int n_checks = 0;
    int n_err    = 0;

    logic [W-1:0] q_model[$];
    int           cnt_a_model = 0;
    int           cnt_b_model = 0;

    pipe_stage_skid #(.PAYLOAD_W(W), .ZERO_BUBBLE(1'b1), .CNT_W(16)) dut_a (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .up_valid_i       (up_valid_i),
        .up_ready_o       (a_up_ready),
        .up_data_i        (up_data_i),
        .down_valid_o     (a_down_valid),
        .down_ready_i     (down_ready_i),
        .down_data_o      (a_down_data),
        .occupancy_o      (a_occ),
        .flush_drop_cnt_o (a_cnt)
    );

    pipe_stage_skid #(.PAYLOAD_W(W), .ZERO_BUBBLE(1'b0), .CNT_W(2)) dut_b (
        .clk_i            (clk),
        .rst_i            (rst_i),
        .flush_i          (flush_i),
        .up_valid_i       (up_valid_i),
        .up_ready_o       (b_up_ready),
        .up_data_i        (up_data_i),
        .down_valid_o     (b_down_valid),
        .down_ready_i     (down_ready_i),
        .down_data_o      (b_down_data),
        .occupancy_o      (b_occ),
        .flush_drop_cnt_o (b_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Compare both instances against the scoreboard model after an edge
    task automatic check_model(input string tag);
        int sz;
        sz = q_model.size();
        chk({tag, "_a_valid"}, W'(a_down_valid), W'(sz != 0));
        chk({tag, "_a_ready"}, W'(a_up_ready),   W'(sz < 2));
        chk({tag, "_a_occ"},   W'(a_occ),        W'(sz));
        chk({tag, "_a_cnt"},   W'(a_cnt),        W'(cnt_a_model));
        chk({tag, "_b_valid"}, W'(b_down_valid), W'(sz != 0));
        chk({tag, "_b_ready"}, W'(b_up_ready),   W'(sz < 2));
        chk({tag, "_b_occ"},   W'(b_occ),        W'(sz));
        chk({tag, "_b_cnt"},   W'(b_cnt),        W'(cnt_b_model));
        if (sz != 0) begin
            chk({tag, "_a_head"}, a_down_data, q_model[0]);
            chk({tag, "_b_head"}, b_down_data, q_model[0]);
        end else begin
            chk({tag, "_a_bubble"}, a_down_data, '0);
        end
    endtask

    // Drive one cycle, update the scoreboard from the model's view of the
    // handshake, then sample one time unit after the rising edge
    task automatic step(input bit rst, input bit flush, input bit uv,
                        input logic [W-1:0] d, input bit dr, input string tag);
        int           occ_before;
        bit           model_ready;
        logic [W-1:0] head;
        rst_i        = rst;
        flush_i      = flush;
        up_valid_i   = uv;
        up_data_i    = d;
        down_ready_i = dr;
        occ_before   = q_model.size();
        model_ready  = (occ_before < 2);
        if (rst) begin
            q_model.delete();
            cnt_a_model = 0;
            cnt_b_model = 0;
        end else begin
            if (dr && occ_before != 0) begin
                head = q_model.pop_front();
                chk({tag, "_sb_a"}, a_down_data, head);
                chk({tag, "_sb_b"}, b_down_data, head);
                $display("xfer %s data=%h", tag, head);
            end
            if (flush) begin
                q_model.delete();
                cnt_a_model = (cnt_a_model + occ_before > 65535) ? 65535 : cnt_a_model + occ_before;
                cnt_b_model = (cnt_b_model + occ_before > 3) ? 3 : cnt_b_model + occ_before;
            end else if (uv && model_ready) begin
                q_model.push_back(d);
            end
        end
        @(posedge clk);
        #1;
        check_model(tag);
    endtask

    typedef struct {
        bit         rst;
        bit         flush;
        bit         uv;
        logic [7:0] d;
        bit         dr;
        bit         ev;
        bit         er;
        logic [1:0] eo;
        logic [7:0] ed;
        int         ec;
    } vec_t;

    vec_t tbl[22];
    int   exp_sat[4];

    initial begin
        rst_i        = 1'b0;
        flush_i      = 1'b0;
        up_valid_i   = 1'b0;
        up_data_i    = '0;
        down_ready_i = 1'b0;

        //          rst flush uv  d      dr  ev er eo    ed     ec
        // reset
        tbl[0]  = '{1, 0, 0, 8'h00, 0, 0, 1, 2'd0, 8'h00, 0};
        tbl[1]  = '{1, 0, 0, 8'h00, 0, 0, 1, 2'd0, 8'h00, 0};
        // stream 1..4 at full throughput
        tbl[2]  = '{0, 0, 1, 8'h01, 1, 1, 1, 2'd1, 8'h01, 0};
        tbl[3]  = '{0, 0, 1, 8'h02, 1, 1, 1, 2'd1, 8'h02, 0};
        tbl[4]  = '{0, 0, 1, 8'h03, 1, 1, 1, 2'd1, 8'h03, 0};
        tbl[5]  = '{0, 0, 1, 8'h04, 1, 1, 1, 2'd1, 8'h04, 0};
        tbl[6]  = '{0, 0, 0, 8'h00, 1, 0, 1, 2'd0, 8'h00, 0};
        // stall absorb: 5 in main, 6 to skid, 7 held upstream
        tbl[7]  = '{0, 0, 1, 8'h05, 0, 1, 1, 2'd1, 8'h05, 0};
        tbl[8]  = '{0, 0, 1, 8'h06, 0, 1, 0, 2'd2, 8'h05, 0};
        tbl[9]  = '{0, 0, 1, 8'h07, 0, 1, 0, 2'd2, 8'h05, 0};
        tbl[10] = '{0, 0, 1, 8'h07, 1, 1, 1, 2'd1, 8'h06, 0};
        tbl[11] = '{0, 0, 1, 8'h07, 1, 1, 1, 2'd1, 8'h07, 0};
        tbl[12] = '{0, 0, 0, 8'h00, 1, 0, 1, 2'd0, 8'h00, 0};
        // flush while FULL, 0x09 must not be captured
        tbl[13] = '{0, 0, 1, 8'h11, 0, 1, 1, 2'd1, 8'h11, 0};
        tbl[14] = '{0, 0, 1, 8'h12, 0, 1, 0, 2'd2, 8'h11, 0};
        tbl[15] = '{0, 1, 1, 8'h09, 0, 0, 1, 2'd0, 8'h00, 2};
        tbl[16] = '{0, 0, 0, 8'h00, 1, 0, 1, 2'd0, 8'h00, 2};
        // flush with a simultaneous out_fire still counts the held entry
        tbl[17] = '{0, 0, 1, 8'h21, 0, 1, 1, 2'd1, 8'h21, 2};
        tbl[18] = '{0, 1, 1, 8'h22, 1, 0, 1, 2'd0, 8'h00, 3};
        // reset and flush together: reset wins
        tbl[19] = '{0, 0, 1, 8'h31, 0, 1, 1, 2'd1, 8'h31, 3};
        tbl[20] = '{1, 1, 1, 8'h32, 0, 0, 1, 2'd0, 8'h00, 0};
        tbl[21] = '{0, 0, 0, 8'h00, 0, 0, 1, 2'd0, 8'h00, 0};

        for (int i = 0; i < 22; i++) begin
            step(tbl[i].rst, tbl[i].flush, tbl[i].uv, W'(tbl[i].d), tbl[i].dr,
                 $sformatf("t%0d", i));
            chk($sformatf("t%0d_valid", i), W'(a_down_valid), W'(tbl[i].ev));
            chk($sformatf("t%0d_ready", i), W'(a_up_ready),   W'(tbl[i].er));
            chk($sformatf("t%0d_occ", i),   W'(a_occ),        W'(tbl[i].eo));
            chk($sformatf("t%0d_data", i),  a_down_data,      W'(tbl[i].ed));
            chk($sformatf("t%0d_cnt", i),   W'(a_cnt),        W'(tbl[i].ec));
        end

        // Counter saturation on the 2-bit instance: four single-entry flushes
        exp_sat[0] = 1;
        exp_sat[1] = 2;
        exp_sat[2] = 3;
        exp_sat[3] = 3;
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 1, W'(8'h40 + k), 0, $sformatf("sat%0d_ld", k));
            step(0, 1, 0, '0, 0, $sformatf("sat%0d_fl", k));
            chk($sformatf("sat%0d_b_cnt", k), W'(b_cnt), W'(exp_sat[k]));
            chk($sformatf("sat%0d_a_cnt", k), W'(a_cnt), W'(k + 1));
        end

        // Bubble behaviour: drain 0xAB to EMPTY
        step(0, 0, 1, W'(8'hAB), 1, "zb_ld");
        step(0, 0, 0, '0, 1, "zb_drain");
        chk("zb_b_valid", W'(b_down_valid), '0);
        chk("zb_b_hold",  b_down_data,      W'(8'hAB));
        chk("zb_a_zero",  a_down_data,      '0);

        // Skid emptied with a wide payload: bit patterns across the full width
        step(0, 0, 1, {1'b1, 70'h2_AAAA_5555_0000_FFFF}, 0, "wide_0");
        step(0, 0, 1, {1'b0, 70'h1_5555_AAAA_FFFF_0000}, 0, "wide_1");
        step(0, 0, 0, '0, 1, "wide_2");
        step(0, 0, 0, '0, 1, "wide_3");

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
